wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Arbitrates completed results from NUM_FU functional units onto the WB_WIDTH ROB writeback ports.
//   Grants at most WB_WIDTH requesters per cycle, round-robin, so that no FU starves.
//   Registers the granted payload and drives the ROB wb_valid / wb_rob_idx / wb_exception / wb_mispred ports.
//   Sits between the FU result stage and the ROB / CDB.
// PARAMETERS
//   NUM_FU     6    number of requesting functional units (>= 1)
//   WB_WIDTH   4    writeback slots per cycle (1..NUM_FU)
//   ROB_DEPTH  64   ROB entries; ROB index width = $clog2(ROB_DEPTH)
//   PHYS_REGS  128  physical registers; tag width = $clog2(PHYS_REGS)
// PORTS
//   clk            in   1                        clock, rising edge
//   reset          in   1                        synchronous, active-high
//   flush_i        in   1                        branch/exception flush from ROB
//   fu_req_i       in   NUM_FU                   FU has a completed result
//   fu_rob_idx_i   in   [NUM_FU][$clog2(ROB_DEPTH)]  ROB index of the result
//   fu_prf_i       in   [NUM_FU][$clog2(PHYS_REGS)]  destination physical tag
//   fu_exception_i in   NUM_FU                   result raised an exception
//   fu_mispred_i   in   NUM_FU                   branch result mispredicted
//   fu_gnt_o       out  NUM_FU                   combinational grant this cycle
//   wb_valid_o     out  WB_WIDTH                 registered slot valid
//   wb_rob_idx_o   out  [WB_WIDTH][$clog2(ROB_DEPTH)]  to ROB wb_rob_idx
//   wb_prf_o       out  [WB_WIDTH][$clog2(PHYS_REGS)]  tag broadcast (CDB)
//   wb_exception_o out  WB_WIDTH                 to ROB wb_exception
//   wb_mispred_o   out  WB_WIDTH                 to ROB wb_mispred
// BEHAVIOUR
//   - Reset (sync): wb_valid_o/wb_rob_idx_o/wb_prf_o/wb_exception_o/wb_mispred_o = 0; rr_ptr = 0.
//     While reset = 1, fu_gnt_o = 0.
//   - State: rr_ptr, $clog2(NUM_FU) bits (min 1), always in 0..NUM_FU-1. There is no other FSM.
//   - Handshake: an FU holds fu_req_i and its payload stable until it sees fu_gnt_o = 1.
//     - req & gnt in cycle N is a transfer. The FU may present a new result in N+1.
//     - fu_gnt_o[i] = 1 only if fu_req_i[i] = 1.
//   - Selection, in cycle N (no reset, no flush):
//     - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
//     - The first WB_WIDTH requesters are granted.
//     - The k-th granted requester in scan order maps to slot k (k = 0..grants-1).
//     - Slots >= grants are invalid.
//   - Latency: one cycle. The payload granted in cycle N appears on the wb_* slot in N+1.
//     wb_valid_o is a registered copy of the slot mask; it is high only for the granted slots.
//     Invalid slots drive 0 on all payload fields.
//   - Pointer update:
//     - If any grant: rr_ptr <= (last granted index + 1) mod NUM_FU.
//     - If no grant: rr_ptr unchanged.
//   - Fairness: a continuously requesting FU is granted within ceil(NUM_FU/WB_WIDTH) cycles.
//   - Flush (flush_i = 1 in cycle N):
//     - fu_gnt_o = 0 in N.
//     - wb_valid_o = 0 in N+1. wb_valid_o does not take the registered slot mask; this overrides the one-cycle latency rule above.
//     - rr_ptr <= 0.
//     - The FUs drop their own squashed requests. The arbiter holds no queued requests.
//   - Simultaneous reset and flush: reset wins (identical visible result).
//   - Reset mid-operation: any in-flight registered slot is discarded. The next cycle shows all outputs 0.
//   - NUM_FU == WB_WIDTH: every requester is granted every cycle. rr_ptr still advances per the pointer-update rule.
//   - Requesters beyond WB_WIDTH receive gnt = 0 and must keep requesting.
//   - Duplicate rob_idx across FUs is an upstream error. It is forwarded as is, with no checking.
// TESTING
//   1. Reset held for 2 cycles with all fu_req_i = 1
//      -> fu_gnt_o = 0; wb_valid_o = 0; after release rr_ptr = 0.
//   2. rr_ptr = 0, fu_req_i = 6'b111111, rob_idx[i] = 10+i
//      -> gnt = 6'b001111; next cycle wb_valid_o = 4'b1111, rob_idx = {10,11,12,13}; rr_ptr = 4.
//   3. Next cycle, with FU4/5 plus new FU0..3 requests
//      -> gnt = 6'b110011; slots hold FU4,FU5,FU0,FU1 in order; rr_ptr = 2.
//   4. Only FU3 requests: rob_idx 17, prf 90, mispred 1
//      -> gnt[3] = 1 in the same cycle; next cycle wb_valid_o = 4'b0001, slot 0 = {17, 90, exc 0, mispred 1};
//      rr_ptr = 4; slots 1..3 all 0.
//   5. All request with flush_i = 1 and rr_ptr = 3
//      -> gnt = 0; next cycle wb_valid_o = 0, rr_ptr = 0; following cycle grants resume from FU0.
//   6. FU5 requests continuously while FU0..4 saturate
//      -> FU5 is granted within 2 cycles every time, checked over 200 random cycles,
//      with a scoreboard checking a one-to-one req -> wb mapping.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks up to WB_WIDTH of NUM_FU completed results per cycle
// in round-robin order and registers them onto the ROB writeback / CDB slots.
module wb_arbiter #(
    parameter int NUM_FU    = 6,
    parameter int WB_WIDTH  = 4,
    parameter int ROB_DEPTH = 64,
    parameter int PHYS_REGS = 128,
    localparam int ROB_W    = $clog2(ROB_DEPTH),
    localparam int PRF_W    = $clog2(PHYS_REGS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_i,
    input  logic [NUM_FU-1:0]                  fu_req_i,
    input  logic [NUM_FU-1:0][ROB_W-1:0]       fu_rob_idx_i,
    input  logic [NUM_FU-1:0][PRF_W-1:0]       fu_prf_i,
    input  logic [NUM_FU-1:0]                  fu_exception_i,
    input  logic [NUM_FU-1:0]                  fu_mispred_i,
    output logic [NUM_FU-1:0]                  fu_gnt_o,
    output logic [WB_WIDTH-1:0]                wb_valid_o,
    output logic [WB_WIDTH-1:0][ROB_W-1:0]     wb_rob_idx_o,
    output logic [WB_WIDTH-1:0][PRF_W-1:0]     wb_prf_o,
    output logic [WB_WIDTH-1:0]                wb_exception_o,
    output logic [WB_WIDTH-1:0]                wb_mispred_o
);

    localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int SLOT_W = (WB_WIDTH > 1) ? $clog2(WB_WIDTH) : 1;
    localparam int CNT_W  = $clog2(WB_WIDTH + 1);

    logic [PTR_W-1:0]                  rr_ptr;
    logic [PTR_W-1:0]                  next_ptr;
    logic [PTR_W-1:0]                  last_idx;
    logic [PTR_W-1:0]                  scan_idx;
    logic [PTR_W:0]                    scan_sum;
    logic [CNT_W-1:0]                  grant_cnt;
    logic                              any_gnt;
    logic [NUM_FU-1:0]                 gnt;

    // Stage 0: combinational slot assembly for the current cycle
    logic [WB_WIDTH-1:0]               vld_p0;
    logic [WB_WIDTH-1:0][ROB_W-1:0]    rob_p0;
    logic [WB_WIDTH-1:0][PRF_W-1:0]    prf_p0;
    logic [WB_WIDTH-1:0]               exc_p0;
    logic [WB_WIDTH-1:0]               mis_p0;

    // Stage 1: registered writeback slots
    logic [WB_WIDTH-1:0]               vld_p1;
    logic [WB_WIDTH-1:0][ROB_W-1:0]    rob_p1;
    logic [WB_WIDTH-1:0][PRF_W-1:0]    prf_p1;
    logic [WB_WIDTH-1:0]               exc_p1;
    logic [WB_WIDTH-1:0]               mis_p1;

    // Round-robin scan from rr_ptr; the k-th winner lands in slot k.
    // Reset and flush suppress every grant, which also leaves all slots empty.
    always_comb begin
        gnt       = '0;
        vld_p0    = '0;
        rob_p0    = '0;
        prf_p0    = '0;
        exc_p0    = '0;
        mis_p0    = '0;
        grant_cnt = '0;
        last_idx  = '0;
        any_gnt   = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (!reset && !flush_i) begin
            for (int k = 0; k < NUM_FU; k++) begin
                scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (scan_sum >= (PTR_W+1)'(NUM_FU)) begin
                    scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
                end
                scan_idx = scan_sum[PTR_W-1:0];
                if (fu_req_i[scan_idx] && (grant_cnt < CNT_W'(WB_WIDTH))) begin
                    gnt[scan_idx]                     = 1'b1;
                    vld_p0[grant_cnt[SLOT_W-1:0]]     = 1'b1;
                    rob_p0[grant_cnt[SLOT_W-1:0]]     = fu_rob_idx_i[scan_idx];
                    prf_p0[grant_cnt[SLOT_W-1:0]]     = fu_prf_i[scan_idx];
                    exc_p0[grant_cnt[SLOT_W-1:0]]     = fu_exception_i[scan_idx];
                    mis_p0[grant_cnt[SLOT_W-1:0]]     = fu_mispred_i[scan_idx];
                    grant_cnt                         = grant_cnt + CNT_W'(1);
                    last_idx                          = scan_idx;
                    any_gnt                           = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the last winner; it stays put on an idle cycle.
    always_comb begin
        next_ptr = rr_ptr;
        if (any_gnt) begin
            if (last_idx == PTR_W'(NUM_FU - 1)) begin
                next_ptr = '0;
            end else begin
                next_ptr = last_idx + PTR_W'(1);
            end
        end
    end

    // Register the slots and the pointer; flush restarts the scan at FU0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            vld_p1 <= '0;
            rob_p1 <= '0;
            prf_p1 <= '0;
            exc_p1 <= '0;
            mis_p1 <= '0;
        end else begin
            rr_ptr <= flush_i ? '0 : next_ptr;
            vld_p1 <= vld_p0;
            rob_p1 <= rob_p0;
            prf_p1 <= prf_p0;
            exc_p1 <= exc_p0;
            mis_p1 <= mis_p0;
        end
    end

    assign fu_gnt_o       = gnt;
    assign wb_valid_o     = vld_p1;
    assign wb_rob_idx_o   = rob_p1;
    assign wb_prf_o       = prf_p1;
    assign wb_exception_o = exc_p1;
    assign wb_mispred_o   = mis_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vectors plus a saturated round-robin run;
// expected writeback records are queued and checked by a separate monitor.
module tb_wb_arbiter;

    typedef struct packed {
        logic [3:0]      v;
        logic [3:0][5:0] rob;
        logic [3:0][6:0] prf;
        logic [3:0]      exc;
        logic [3:0]      mis;
    } wb_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush_i = 1'b0;
    logic [5:0]      fu_req_i = '0;
    logic [5:0][5:0] fu_rob_idx_i = '0;
    logic [5:0][6:0] fu_prf_i = '0;
    logic [5:0]      fu_exception_i = '0;
    logic [5:0]      fu_mispred_i = '0;
    logic [5:0]      fu_gnt_o;
    logic [3:0]      wb_valid_o;
    logic [3:0][5:0] wb_rob_idx_o;
    logic [3:0][6:0] wb_prf_o;
    logic [3:0]      wb_exception_o;
    logic [3:0]      wb_mispred_o;

    // next payload each FU presents, copied onto the ports at the negedge
    logic [5:0][5:0] nx_rob = '0;
    logic [5:0][6:0] nx_prf = '0;
    logic [5:0]      nx_exc = '0;
    logic [5:0]      nx_mis = '0;

    wb_t   exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    wb_arbiter #(.NUM_FU(6), .WB_WIDTH(4), .ROB_DEPTH(64), .PHYS_REGS(128)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .fu_req_i(fu_req_i), .fu_rob_idx_i(fu_rob_idx_i), .fu_prf_i(fu_prf_i),
        .fu_exception_i(fu_exception_i), .fu_mispred_i(fu_mispred_i),
        .fu_gnt_o(fu_gnt_o), .wb_valid_o(wb_valid_o), .wb_rob_idx_o(wb_rob_idx_o),
        .wb_prf_o(wb_prf_o), .wb_exception_o(wb_exception_o), .wb_mispred_o(wb_mispred_o)
    );

    always #5 clk = ~clk;

    function automatic wb_t mk(input logic [3:0] v, input logic [3:0][5:0] rob,
                               input logic [3:0][6:0] prf, input logic [3:0] exc,
                               input logic [3:0] mis);
        wb_t w;
        w.v = v; w.rob = rob; w.prf = prf; w.exc = exc; w.mis = mis;
        return w;
    endfunction

    // apply one cycle of stimulus, check the same-cycle grant, queue the writeback
    task automatic drive(input logic rst, input logic fl, input logic [5:0] req,
                         input logic [5:0] exp_gnt, input wb_t exp_wb, input string name);
        @(negedge clk);
        reset          = rst;
        flush_i        = fl;
        fu_req_i       = req;
        fu_rob_idx_i   = nx_rob;
        fu_prf_i       = nx_prf;
        fu_exception_i = nx_exc;
        fu_mispred_i   = nx_mis;
        #1;
        n_cmp++;
        if (fu_gnt_o !== exp_gnt) begin
            n_bad++;
            $display("FAIL gnt_%s: got %b expected %b", name, fu_gnt_o, exp_gnt);
        end
        exp_q.push_back(exp_wb);
        name_q.push_back(name);
    endtask

    // monitor: one queued record per clock, compared just after the edge
    initial begin
        wb_t   e;
        wb_t   a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = mk(wb_valid_o, wb_rob_idx_o, wb_prf_o, wb_exception_o, wb_mispred_o);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL wb_%s: got v=%b rob=%h prf=%h exc=%b mis=%b expected v=%b rob=%h prf=%h exc=%b mis=%b",
                             nm, a.v, a.rob, a.prf, a.exc, a.mis, e.v, e.rob, e.prf, e.exc, e.mis);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_t        z;
        wb_t        ex;
        logic [5:0] m_gnt;
        logic [2:0] idx;
        logic [1:0] slot;
        int         m_ptr;
        int         cnt;
        int         last;
        int         wait5;
        logic [5:0] tok;

        z = '0;

        // reset held two cycles while everyone requests
        drive(1, 0, 6'h3f, 6'b000000, z, "reset0");
        drive(1, 0, 6'h3f, 6'b000000, z, "reset1");

        // all request from rr_ptr 0
        for (int i = 0; i < 6; i++) begin
            nx_rob[i] = 6'(10 + i);
            nx_prf[i] = 7'(20 + i);
        end
        drive(0, 0, 6'h3f, 6'b001111,
              mk(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, {7'd23, 7'd22, 7'd21, 7'd20}, 4'b0, 4'b0),
              "all_ptr0");

        // FU4/5 still waiting, FU0..3 present new results; rr_ptr 4
        for (int i = 0; i < 4; i++) begin
            nx_rob[i] = 6'(30 + i);
            nx_prf[i] = 7'(40 + i);
        end
        drive(0, 0, 6'h3f, 6'b110011,
              mk(4'b1111, {6'd31, 6'd30, 6'd15, 6'd14}, {7'd41, 7'd40, 7'd25, 7'd24}, 4'b0, 4'b0),
              "wrap_ptr4");

        // only FU3, mispredicted branch; rr_ptr 2
        nx_rob[3] = 6'd17; nx_prf[3] = 7'd90; nx_mis[3] = 1'b1;
        drive(0, 0, 6'b001000, 6'b001000,
              mk(4'b0001, {6'd0, 6'd0, 6'd0, 6'd17}, {7'd0, 7'd0, 7'd0, 7'd90}, 4'b0, 4'b0001),
              "single_fu3");
        nx_mis[3] = 1'b0;

        // idle cycle: nothing granted, pointer stays at 4
        drive(0, 0, 6'b000000, 6'b000000, z, "idle");

        // FU0 and FU2 from rr_ptr 4: FU0 is scanned first
        nx_rob[0] = 6'd1; nx_prf[0] = 7'd2;
        nx_rob[2] = 6'd5; nx_prf[2] = 7'd6; nx_exc[2] = 1'b1;
        drive(0, 0, 6'b000101, 6'b000101,
              mk(4'b0011, {6'd0, 6'd0, 6'd5, 6'd1}, {7'd0, 7'd0, 7'd6, 7'd2}, 4'b0010, 4'b0),
              "order_ptr4");
        nx_exc[2] = 1'b0;

        // flush with rr_ptr 3
        drive(0, 1, 6'h3f, 6'b000000, z, "flush");

        // grants resume from FU0
        for (int i = 0; i < 6; i++) begin
            nx_rob[i] = 6'(50 + i);
            nx_prf[i] = 7'(60 + i);
        end
        nx_exc[1] = 1'b1; nx_mis[3] = 1'b1;
        drive(0, 0, 6'h3f, 6'b001111,
              mk(4'b1111, {6'd53, 6'd52, 6'd51, 6'd50}, {7'd63, 7'd62, 7'd61, 7'd60}, 4'b0010, 4'b1000),
              "after_flush");

        // reset and flush together mid-operation (rr_ptr 4)
        drive(1, 1, 6'h3f, 6'b000000, z, "reset_flush");

        // pointer back at 0
        drive(0, 0, 6'h3f, 6'b001111,
              mk(4'b1111, {6'd53, 6'd52, 6'd51, 6'd50}, {7'd63, 7'd62, 7'd61, 7'd60}, 4'b0010, 4'b1000),
              "after_reset");

        // saturated run: every FU always requests, payloads replaced on transfer
        m_ptr = 4;
        wait5 = 0;
        tok   = 6'd0;
        for (int i = 0; i < 6; i++) begin
            nx_rob[i] = tok; tok++;
            nx_prf[i] = 7'($urandom);
            nx_exc[i] = 1'($urandom);
            nx_mis[i] = 1'($urandom);
        end
        for (int c = 0; c < 200; c++) begin
            m_gnt = '0;
            ex    = '0;
            cnt   = 0;
            last  = 0;
            for (int k = 0; k < 6; k++) begin
                idx = 3'((m_ptr + k) % 6);
                if (cnt < 4) begin
                    slot          = 2'(cnt);
                    m_gnt[idx]    = 1'b1;
                    ex.v[slot]    = 1'b1;
                    ex.rob[slot]  = nx_rob[idx];
                    ex.prf[slot]  = nx_prf[idx];
                    ex.exc[slot]  = nx_exc[idx];
                    ex.mis[slot]  = nx_mis[idx];
                    cnt++;
                    last = int'(idx);
                end
            end
            m_ptr = (last + 1) % 6;
            drive(0, 0, 6'h3f, m_gnt, ex, "saturate");

            if (fu_gnt_o[5]) wait5 = 0;
            else             wait5++;
            n_cmp++;
            if (wait5 > 1) begin
                n_bad++;
                $display("FAIL fu5_starve: waited %0d cycles required at most 1", wait5);
            end

            for (int i = 0; i < 6; i++) begin
                if (m_gnt[i]) begin
                    nx_rob[i] = tok; tok++;
                    nx_prf[i] = 7'($urandom);
                    nx_exc[i] = 1'($urandom);
                    nx_mis[i] = 1'($urandom);
                end
            end
        end

        @(negedge clk);
        fu_req_i = '0;
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
